// File: rtl/trigger_link_framer.sv
// Trigger-link framer: maps per-BX cluster groups onto NUM_LINKS GTX lanes as
// 4-word K-character frames, with masking, test patterns, error injection and resync.
module trigger_link_framer #(
   parameter int          NUM_LINKS       = 4,
   parameter int          NUM_GROUPS      = 2,
   parameter int          LTNCY_PERIOD    = 128,
   parameter logic [13:0] INVALID_CLUSTER = 14'h3FFF
) (
   input  logic                      clk_160,
   input  logic                      reset_n,
   input  logic                      bx_strobe,
   input  logic [56*NUM_GROUPS-1:0]  clusters,
   input  logic                      overflow,
   input  logic [NUM_LINKS-1:0]      link_en,
   input  logic [1:0]                mode,
   input  logic                      inj_err,
   output logic [16*NUM_LINKS-1:0]   tx_data,
   output logic [2*NUM_LINKS-1:0]    tx_isk,
   output logic                      ltncy_trig,
   output logic [15:0]               resync_cnt
);

   localparam logic [15:0] IDLE_WORD = 16'h00BC;
   localparam logic [7:0]  BX_LAST   = 8'(LTNCY_PERIOD - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t      state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic        start, resync;

   logic                      vld_p0_q, stb_p0_q, ovf_p0_q;
   logic [1:0]                mode_p0_q;
   logic [NUM_LINKS-1:0]      en_p0_q;
   logic [56*NUM_GROUPS-1:0]  clus_p0_q;

   logic                      vld_p1_q, marker_p1_q, idle_p1_q;
   logic [1:0]                wsel_q;
   logic [7:0]                comma_p1_q;
   logic [NUM_LINKS-1:0]      en_p1_q;
   logic [55:0]               pay_p1_q [NUM_GROUPS];

   logic [7:0]   bx_cnt_q, bx_cnt_d;
   logic [6:0]   prbs_q, prbs_d;
   logic         ovf_pend_q, ovf_pend_d, inj_pend_q, inj_pend_d;
   logic [15:0]  resync_q;

   logic                      marker_d, ovf_in;
   logic [7:0]                comma_d;
   logic [55:0]               prbs_pay, pay_d [NUM_GROUPS];
   logic [62:0]               prbs_adv;

   logic [16*NUM_LINKS-1:0]   tx_data_q, tx_data_d;
   logic [2*NUM_LINKS-1:0]    tx_isk_q, tx_isk_d;
   logic                      trig_q, trig_d, inj_fire;
   logic [15:0]               word;
   logic [1:0]                isk;
   logic [55:0]               pay_sel;

   // Returns {next state, 56 payload bits}; bit 0 is the first bit generated.
   function automatic logic [62:0] prbs7_adv(input logic [6:0] s);
      logic [6:0]  r;
      logic [55:0] p;
      logic        b;
      r = s;
      p = '0;
      for (int i = 0; i < 56; i++) begin
         b    = r[6] ^ r[5];
         p[i] = b;
         r    = {r[5:0], b};
      end
      return {r, p};
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk_160 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         phase_q <= 2'd0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
      end
   end

   // Any strobe in RUN starts a frame; only one seen at phase 3 is aligned.
   always_comb begin
      state_d = state_q;
      phase_d = 2'd0;
      start   = 1'b0;
      resync  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bx_strobe) begin
               state_d = S_RUN;
               start   = 1'b1;
            end
         end
         S_RUN: begin
            phase_d = phase_q + 2'd1;
            start   = bx_strobe || (phase_q == 2'd3);
            resync  = bx_strobe && (phase_q != 2'd3);
            if (start) phase_d = 2'd0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---- stage p0: capture frame inputs at frame start ----
   always_ff @(posedge clk_160 or negedge reset_n) begin
      if (!reset_n) begin
         vld_p0_q <= 1'b0;
         resync_q <= 16'd0;
      end else begin
         vld_p0_q <= start;
         if (resync) resync_q <= sat_inc16(resync_q);
      end
   end

   always_ff @(posedge clk_160) begin
      if (start) begin
         stb_p0_q  <= bx_strobe;
         ovf_p0_q  <= overflow;
         mode_p0_q <= mode;
         en_p0_q   <= link_en;
         clus_p0_q <= clusters;
      end
   end

   // ---- stage p1: build payload, comma and marker ----
   always_comb begin
      marker_d   = (bx_cnt_q == 8'd0) && (mode_p0_q != 2'd3);
      ovf_in     = stb_p0_q && ovf_p0_q;
      prbs_adv   = prbs7_adv(prbs_q);
      prbs_pay   = prbs_adv[55:0];
      prbs_d     = (mode_p0_q == 2'd1) ? prbs_adv[62:56] : prbs_q;
      bx_cnt_d   = (bx_cnt_q == BX_LAST) ? 8'd0 : bx_cnt_q + 8'd1;
      comma_d    = 8'hBC;
      ovf_pend_d = ovf_pend_q || ovf_in;
      // A marker frame outranks overflow, which then waits for the next frame.
      if (mode_p0_q != 2'd3) begin
         if (marker_d) begin
            comma_d = 8'hFC;
         end else if (ovf_pend_q || ovf_in) begin
            comma_d    = 8'h3C;
            ovf_pend_d = 1'b0;
         end
      end
      for (int g = 0; g < NUM_GROUPS; g++) begin
         case (mode_p0_q)
            2'd0:    pay_d[g] = stb_p0_q ? clus_p0_q[56*g +: 56] : {4{INVALID_CLUSTER}};
            2'd1:    pay_d[g] = prbs_pay;
            2'd2:    pay_d[g] = {7{bx_cnt_q}};
            default: pay_d[g] = '0;
         endcase
      end
   end

   always_ff @(posedge clk_160 or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1_q   <= 1'b0;
         wsel_q     <= 2'd0;
         bx_cnt_q   <= 8'd0;
         prbs_q     <= 7'h7F;
         ovf_pend_q <= 1'b0;
      end else if (vld_p0_q) begin
         vld_p1_q   <= 1'b1;
         wsel_q     <= 2'd0;
         bx_cnt_q   <= bx_cnt_d;
         prbs_q     <= prbs_d;
         ovf_pend_q <= ovf_pend_d;
      end else begin
         wsel_q     <= wsel_q + 2'd1;
      end
   end

   always_ff @(posedge clk_160) begin
      if (vld_p0_q) begin
         marker_p1_q <= marker_d;
         idle_p1_q   <= (mode_p0_q == 2'd3);
         comma_p1_q  <= comma_d;
         en_p1_q     <= en_p0_q;
         for (int g = 0; g < NUM_GROUPS; g++) pay_p1_q[g] <= pay_d[g];
      end
   end

   // ---- stage p2: word select, lane masking, error injection ----
   always_comb begin
      tx_data_d  = '0;
      tx_isk_d   = '0;
      word       = IDLE_WORD;
      isk        = 2'b01;
      pay_sel    = '0;
      inj_fire   = vld_p1_q && (wsel_q == 2'd1) && inj_pend_q;
      inj_pend_d = (inj_pend_q && !inj_fire) || inj_err;
      trig_d     = vld_p1_q && (wsel_q == 2'd0) && marker_p1_q;
      for (int i = 0; i < NUM_LINKS; i++) begin
         word    = IDLE_WORD;
         isk     = 2'b01;
         pay_sel = pay_p1_q[i % NUM_GROUPS];
         if (vld_p1_q && !idle_p1_q && en_p1_q[i]) begin
            case (wsel_q)
               2'd0:    begin word = {pay_sel[7:0], comma_p1_q}; isk = 2'b01; end
               2'd1:    begin word = pay_sel[23:8];  isk = 2'b00; end
               2'd2:    begin word = pay_sel[39:24]; isk = 2'b00; end
               default: begin word = pay_sel[55:40]; isk = 2'b00; end
            endcase
         end
         if (inj_fire && en_p1_q[i]) word[0] = ~word[0];
         tx_data_d[16*i +: 16] = word;
         tx_isk_d[2*i +: 2]    = isk;
      end
   end

   always_ff @(posedge clk_160 or negedge reset_n) begin
      if (!reset_n) begin
         tx_data_q  <= {NUM_LINKS{IDLE_WORD}};
         tx_isk_q   <= {NUM_LINKS{2'b01}};
         trig_q     <= 1'b0;
         inj_pend_q <= 1'b0;
      end else begin
         tx_data_q  <= tx_data_d;
         tx_isk_q   <= tx_isk_d;
         trig_q     <= trig_d;
         inj_pend_q <= inj_pend_d;
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_isk     = tx_isk_q;
   assign ltncy_trig = trig_q;
   assign resync_cnt = resync_q;

endmodule

// File: tb/tb_trigger_link_framer.sv
// Bench for trigger_link_framer: frame-level reference model feeding a
// cycle-stamped expectation queue, driven from a vector table plus directed sequences.
module tb_trigger_link_framer;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          bx_strobe;
   logic [111:0]  clusters;
   logic          overflow;
   logic [3:0]    link_en;
   logic [1:0]    mode;
   logic          inj_err;
   logic [63:0]   tx_data;
   logic [7:0]    tx_isk;
   logic          ltncy_trig;
   logic [15:0]   resync_cnt;

   always #5 clk = ~clk;

   trigger_link_framer dut (
      .clk_160(clk), .reset_n(reset_n), .bx_strobe(bx_strobe), .clusters(clusters),
      .overflow(overflow), .link_en(link_en), .mode(mode), .inj_err(inj_err),
      .tx_data(tx_data), .tx_isk(tx_isk), .ltncy_trig(ltncy_trig), .resync_cnt(resync_cnt)
   );

   typedef struct {
      int          cyc;
      logic [63:0] data;
      logic [7:0]  isk;
      logic        trig;
      string       nm;
   } exp_t;

   typedef struct {
      logic         stb;
      logic [111:0] cl;
      logic         ovf;
      logic [1:0]   md;
      logic [3:0]   en;
      logic         inj;
      int           ncyc;
      logic [7:0]   xc;
      string        nm;
   } vec_t;

   exp_t  sb[$];
   vec_t  tbl[$];
   int    cyc = 0;
   int    n_chk = 0;
   int    n_fail = 0;
   int    m_bx;
   logic  m_ovf;
   logic [6:0] m_prbs;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   task automatic mon_step();
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_chk++;
         if (e.cyc != cyc || tx_data !== e.data || tx_isk !== e.isk || ltncy_trig !== e.trig) begin
            n_fail++;
            $display("FAIL %s @%0d (due %0d): data=%h isk=%h trig=%b, expected data=%h isk=%h trig=%b",
                     e.nm, cyc, e.cyc, tx_data, tx_isk, ltncy_trig, e.data, e.isk, e.trig);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon_step();
   endtask

   // PRBS-7 from the recurrence b[n] = b[n-6] ^ b[n-7]; returns {next state, payload}.
   function automatic logic [62:0] prbs_ref(input logic [6:0] s);
      logic [62:0] seq;
      logic [6:0]  ns;
      for (int j = 0; j < 7; j++) seq[j] = s[6-j];
      for (int j = 7; j < 63; j++) seq[j] = seq[j-6] ^ seq[j-7];
      for (int k = 0; k < 7; k++) ns[k] = seq[62-k];
      return {ns, seq[62:7]};
   endfunction

   task automatic addv(input logic stb, input logic [111:0] cl, input logic ovf, input logic [1:0] md,
                       input logic [3:0] en, input logic inj, input int ncyc, input logic [7:0] xc,
                       input string nm);
      vec_t v;
      v.stb = stb; v.cl = cl; v.ovf = ovf; v.md = md; v.en = en;
      v.inj = inj; v.ncyc = ncyc; v.xc = xc; v.nm = nm;
      tbl.push_back(v);
   endtask

   // Drive one frame starting at the next edge, and queue its expected output words.
   task automatic frame(input vec_t v);
      logic [55:0] pay [2];
      logic [62:0] pr;
      logic [7:0]  cm;
      logic        mk, oi;
      logic [15:0] wd;
      logic [1:0]  ik;
      exp_t        e;
      int          nw;
      mk = (m_bx == 0) && (v.md != 2'd3);
      oi = v.stb && v.ovf;
      cm = 8'hBC;
      if (v.md == 2'd3) m_ovf = m_ovf | oi;
      else if (mk) begin cm = 8'hFC; m_ovf = m_ovf | oi; end
      else if (m_ovf || oi) begin cm = 8'h3C; m_ovf = 1'b0; end
      if (v.xc != 8'h00) cm = v.xc;
      pr = prbs_ref(m_prbs);
      if (v.md == 2'd1) m_prbs = pr[62:56];
      for (int g = 0; g < 2; g++) begin
         case (v.md)
            2'd0:    pay[g] = v.stb ? v.cl[56*g +: 56] : {4{14'h3FFF}};
            2'd1:    pay[g] = pr[55:0];
            2'd2:    pay[g] = {7{8'(m_bx)}};
            default: pay[g] = '0;
         endcase
      end
      m_bx = (m_bx + 1) % 128;
      nw = (v.ncyc < 4) ? v.ncyc : 4;
      for (int k = 0; k < nw; k++) begin
         e.cyc = cyc + 3 + k;
         e.nm  = $sformatf("%s.w%0d", v.nm, k);
         e.trig = (k == 0) && mk;
         for (int i = 0; i < 4; i++) begin
            wd = 16'h00BC;
            ik = 2'b01;
            if (v.en[i] && v.md != 2'd3) begin
               case (k)
                  0:       begin wd = {pay[i%2][7:0], cm}; ik = 2'b01; end
                  1:       begin wd = pay[i%2][23:8];  ik = 2'b00; end
                  2:       begin wd = pay[i%2][39:24]; ik = 2'b00; end
                  default: begin wd = pay[i%2][55:40]; ik = 2'b00; end
               endcase
            end
            if (k == 1 && v.inj && v.en[i]) wd[0] = ~wd[0];
            e.data[16*i +: 16] = wd;
            e.isk[2*i +: 2]    = ik;
         end
         sb.push_back(e);
      end
      bx_strobe = v.stb; clusters = v.cl; overflow = v.ovf;
      mode = v.md; link_en = v.en; inj_err = v.inj;
      tick();
      bx_strobe = 1'b0; overflow = 1'b0; inj_err = 1'b0;
      repeat (v.ncyc - 1) tick();
   endtask

   function automatic logic [111:0] rnd112();
      logic [127:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      return r[111:0];
   endfunction

   initial begin
      vec_t v;
      reset_n = 1'b0; bx_strobe = 1'b0; clusters = '0; overflow = 1'b0;
      link_en = 4'hF; mode = 2'd0; inj_err = 1'b0;
      repeat (3) tick();
      chk("rst_data", tx_data, {4{16'h00BC}});
      chk("rst_isk", 64'(tx_isk), 64'h55);
      chk("rst_trig", 64'(ltncy_trig), 64'h0);
      chk("rst_resync", 64'(resync_cnt), 64'h0);
      reset_n = 1'b1;
      repeat (3) tick();
      chk("idle_data", tx_data, {4{16'h00BC}});
      chk("idle_isk", 64'(tx_isk), 64'h55);
      m_bx = 0; m_ovf = 1'b0; m_prbs = 7'h7F;

      addv(1, {56'hFEDCBA98765432, 56'h0123456789ABCD}, 0, 2'd0, 4'hF, 0, 4, 8'hFC, "frame1_marker");
      addv(1, {56'h11111111111111, 56'h23456789ABCDEF}, 0, 2'd0, 4'hF, 0, 4, 8'hBC, "data_k285");
      addv(1, {56'h0A0B0C0D0E0F10, 56'h31415926535897}, 1, 2'd0, 4'hF, 0, 4, 8'h3C, "ovf_k281");
      addv(1, {56'h27182818284590, 56'h16180339887498}, 0, 2'd0, 4'hF, 0, 4, 8'hBC, "ovf_cleared");
      addv(0, {56'h55555555555555, 56'hAAAAAAAAAAAAAA}, 0, 2'd0, 4'hF, 0, 4, 8'hBC, "no_strobe_inv");
      addv(0, '0,                                       0, 2'd0, 4'hF, 0, 4, 8'hBC, "no_strobe_inv2");
      addv(1, {56'h01020304050607, 56'h08090A0B0C0D0E}, 0, 2'd2, 4'hF, 0, 4, 8'hBC, "counter_mode");
      addv(1, {56'h13579BDF02468A, 56'hFEEDFACECAFE01}, 0, 2'd0, 4'b0101, 1, 4, 8'hBC, "mask_inj");
      addv(1, {56'h99999999999999, 56'h88888888888888}, 0, 2'd3, 4'hF, 0, 4, 8'h00, "idle_mode");
      addv(1, {56'hC0FFEE00C0FFEE, 56'hDEADBEEF123456}, 0, 2'd0, 4'hF, 0, 4, 8'hBC, "after_inj");
      addv(1, {56'h77777777777777, 56'h66666666666666}, 0, 2'd0, 4'hF, 0, 2, 8'hBC, "abandoned");
      addv(1, {56'h44444444444444, 56'h3333333333ABCD}, 0, 2'd0, 4'hF, 0, 4, 8'hBC, "resync_frame");
      for (int r = 0; r < tbl.size(); r++) frame(tbl[r]);
      chk("resync_one", 64'(resync_cnt), 64'h1);

      // Run past a bx_cnt wrap with overflow raised on the marker BX.
      for (int n = 0; n < 130; n++) begin
         v.stb = 1; v.cl = rnd112(); v.ovf = (m_bx == 0); v.md = 2'd0; v.en = 4'hF;
         v.inj = 0; v.ncyc = 4; v.xc = 8'h00; v.nm = $sformatf("run%0d", n);
         frame(v);
      end

      // Continuous strobes: every one after the first is misaligned.
      bx_strobe = 1'b1; clusters = rnd112(); mode = 2'd0; link_en = 4'hF;
      repeat (65540) tick();
      bx_strobe = 1'b0;
      repeat (3) tick();
      m_bx = (m_bx + 65540) % 128;
      chk("resync_sat", 64'(resync_cnt), 64'hFFFF);
      for (int n = 0; n < 3; n++) begin
         v.stb = 1; v.cl = rnd112(); v.ovf = 0; v.md = 2'd0; v.en = 4'hF;
         v.inj = 0; v.ncyc = 4; v.xc = 8'h00; v.nm = $sformatf("post_burst%0d", n);
         frame(v);
      end
      repeat (4) tick();
      chk("drain1", 64'(sb.size()), 64'h0);

      // Reset in the middle of a frame, then PRBS from the seed.
      bx_strobe = 1'b1; tick(); bx_strobe = 1'b0; tick();
      reset_n = 1'b0;
      #1;
      chk("midrst_data", tx_data, {4{16'h00BC}});
      chk("midrst_isk", 64'(tx_isk), 64'h55);
      chk("midrst_resync", 64'(resync_cnt), 64'h0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      m_bx = 0; m_ovf = 1'b0; m_prbs = 7'h7F;
      v.stb = 1; v.cl = rnd112(); v.ovf = 0; v.md = 2'd1; v.en = 4'hF; v.inj = 0; v.ncyc = 4;
      v.xc = 8'hFC; v.nm = "prbs0"; frame(v);
      v.xc = 8'hBC; v.nm = "prbs1"; v.cl = rnd112(); frame(v);
      v.xc = 8'hBC; v.nm = "cnt_after_prbs"; v.md = 2'd2; frame(v);
      repeat (6) tick();
      chk("drain2", 64'(sb.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
